park_slot_manager: RTL and testbench
====================================

Name: park_slot_manager

Overview:
Sequential occupancy keeper for the car park; sits directly downstream of the entry stage.
- Holds the 8-slot occupancy register that drives parking_capacity into the entry stage.
- Consumes the returned park_number.
- Runs the entry-gate handshake, then commits or releases the slot.
- Processes car exits.

Parameters:
GATE_TIMEOUT, 16, cycles the gate stays open waiting for car_passed before the entry is aborted (range 2..255)
SLOTS, 8, number of park slots; fixed at 8 to match the 3-bit park_number

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
entry  input  1  car at entry gate requests a slot (level; sampled in IDLE only)
park_number  input  3  slot chosen by the entry stage from parking_capacity
car_passed  input  1  entry gate sensor, 1-cycle pulse when the car has gone through
exit_req  input  1  1-cycle pulse, a car is leaving
exit_slot  input  3  slot being vacated, valid with exit_req
parking_capacity  output  8  occupancy bitmap, bit i = 1 means slot i occupied or reserved
gate_open  output  1  entry gate open command
ticket_valid  output  1  1-cycle pulse, ticket issued
ticket_slot  output  3  slot printed on ticket, held until next ticket
full  output  1  all 8 bits of parking_capacity set
free_count  output  4  number of zero bits in parking_capacity (0..8)
deny  output  1  1-cycle pulse, entry refused because full
exit_err  output  1  1-cycle pulse, illegal exit ignored

Behaviour:
Reset (rst=1 at a clk edge):
- All outputs go to 0, except free_count = 8.
- FSM goes to IDLE and the timeout counter clears.
- Reset mid-handshake drops the reservation and closes the gate immediately.

States: IDLE, GRANT, WAIT_CAR.

IDLE:
- entry=1 and full=0 → latch park_number into resv_slot, set that occupancy bit (reservation), assert ticket_valid for 1 cycle, load ticket_slot, go to GRANT.
- entry=1 and full=1 → pulse deny, stay in IDLE.

GRANT (1 cycle):
- Set gate_open=1, clear the counter, go to WAIT_CAR.

WAIT_CAR:
- gate_open=1 and the counter increments each cycle.
- car_passed=1 → gate_open=0 next cycle, bit stays set (commit), go to IDLE.
- Counter reaches GATE_TIMEOUT-1 without car_passed → clear the resv_slot bit, gate_open=0, go to IDLE.
- car_passed and timeout in the same cycle → car_passed wins (commit).

Latency:
- Entry to ticket_valid: 1 cycle.
- Entry to gate_open: 2 cycles.
- Occupancy changes are visible on parking_capacity the cycle after the causing edge.

Exit (any state):
- exit_req with exit_slot bit = 1 and exit_slot ≠ resv_slot-while-reserved → clear the bit.
- exit_req on a free slot, or on the currently reserved slot → pulse exit_err, no change.

Simultaneous events:
- An exit and a reservation on different slots in the same cycle both apply.
- The entry full check uses the pre-exit bitmap, so a same-cycle exit does not rescue a full lot; deny still pulses.

Derived outputs:
- free_count and full are registered, derived from the next-state bitmap, and consistent with parking_capacity in the same cycle.

Inputs:
- park_number is trusted. If the indicated bit is already set (entry-stage fault), the entry is treated as deny.

Optional Feature:
Macro: PARK_STATS_EN.
- Defined: adds output total_entries [15:0], a saturating count of committed entries (car_passed commits only), and output total_timeouts [7:0], a saturating count of aborted entries. Both reset to 0.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Shared package park_pkg holds: the state encoding (IDLE=2'd0, GRANT=2'd1, WAIT_CAR=2'd2), SLOT_W=3, SLOTS=8, and the default timeout constant.
- One natural sub-module, park_popcount: combinational 8-bit to 4-bit zero counter producing free_count.
- The FSM and the occupancy register remain in park_slot_manager.

Test Plan:
1. Reset, then idle 3 cycles → parking_capacity=8'h00, free_count=8, full=0, gate_open=0.
2. entry=1 with park_number=3, car_passed 4 cycles after gate_open → ticket_valid pulse with ticket_slot=3; capacity=8'h08 from the next cycle; gate closes after the pass; free_count=7.
3. Reserve slot 5, never pulse car_passed → gate_open held for 16 cycles, then capacity bit 5 cleared and capacity back to its prior value (8'h08); with PARK_STATS_EN, total_timeouts=1.
4. Preload capacity to 8'hFF via 8 entries, then entry=1 → deny pulse, no gate_open, full=1, free_count=0.
5. Capacity 8'hFF in IDLE, exit_req slot 2 while entry=1 in the same cycle → bit 2 cleared (8'hFB), deny pulses; next cycle entry succeeds with park_number=2.
6. exit_req on free slot 6, and exit_req on the reserved slot during WAIT_CAR → exit_err pulse each time, capacity unchanged; assert rst during WAIT_CAR → next cycle all outputs at reset values.

Source files
------------

// File: rtl/park_pkg.sv
// Shared definitions for the car-park slot manager: FSM encoding, slot
// geometry and the default gate timeout.
package park_pkg;

  localparam int SLOTS            = 8;
  localparam int SLOT_W           = 3;
  localparam int GATE_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_CAR = 2'd2
  } state_e;

endpackage : park_pkg

// File: rtl/park_slot_manager_if.sv
// Signal bundle between the car-park environment (master) and the slot
// manager (slave). The PARK_STATS_EN macro adds the statistics counters.
interface park_slot_manager_if;
  import park_pkg::*;

  logic              entry;
  logic [SLOT_W-1:0] park_number;
  logic              car_passed;
  logic              exit_req;
  logic [SLOT_W-1:0] exit_slot;
  logic [SLOTS-1:0]  parking_capacity;
  logic              gate_open;
  logic              ticket_valid;
  logic [SLOT_W-1:0] ticket_slot;
  logic              full;
  logic [3:0]        free_count;
  logic              deny;
  logic              exit_err;
`ifdef PARK_STATS_EN
  logic [15:0]       total_entries;
  logic [7:0]        total_timeouts;

  modport master (
    output entry, park_number, car_passed, exit_req, exit_slot,
    input  parking_capacity, gate_open, ticket_valid, ticket_slot, full,
           free_count, deny, exit_err, total_entries, total_timeouts
  );

  modport slave (
    input  entry, park_number, car_passed, exit_req, exit_slot,
    output parking_capacity, gate_open, ticket_valid, ticket_slot, full,
           free_count, deny, exit_err, total_entries, total_timeouts
  );
`else
  modport master (
    output entry, park_number, car_passed, exit_req, exit_slot,
    input  parking_capacity, gate_open, ticket_valid, ticket_slot, full,
           free_count, deny, exit_err
  );

  modport slave (
    input  entry, park_number, car_passed, exit_req, exit_slot,
    output parking_capacity, gate_open, ticket_valid, ticket_slot, full,
           free_count, deny, exit_err
  );
`endif

endinterface : park_slot_manager_if

// File: rtl/park_popcount.sv
// Counts the free (zero) bits of the occupancy bitmap.
module park_popcount
  import park_pkg::*;
(
  input  logic [SLOTS-1:0] map_i,
  output logic [3:0]       zeros_o
);

  // Sum the inverted occupancy bits.
  always_comb begin
    zeros_o = 4'd0;
    for (int i = 0; i < SLOTS; i++) begin
      zeros_o = zeros_o + {3'b000, ~map_i[i]};
    end
  end

endmodule : park_popcount

// File: rtl/park_slot_manager.sv
// Car-park occupancy keeper: owns the 8-slot bitmap, runs the entry-gate
// handshake (IDLE -> GRANT -> WAIT_CAR) and processes exits.
// Optional macro PARK_STATS_EN adds saturating entry/timeout counters.
module park_slot_manager
  import park_pkg::*;
#(
  parameter int GATE_TIMEOUT = GATE_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  park_slot_manager_if.slave  bus
);

  localparam logic [7:0] TO_LAST = 8'(GATE_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [SLOTS-1:0]  cap_q, cap_d;
  logic [SLOT_W-1:0] resv_q, resv_d;
  logic [SLOT_W-1:0] tslot_q, tslot_d;
  logic              gate_q, gate_d;
  logic              tvalid_q, tvalid_d;
  logic              deny_q, deny_d;
  logic              exit_err_q, exit_err_d;
  logic              full_q, full_d;
  logic [3:0]        free_q, free_d;
  logic              commit, abort;
  logic              reserved;

  // Next-state logic for the FSM, the occupancy bitmap and the pulses.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    resv_d     = resv_q;
    tslot_d    = tslot_q;
    gate_d     = gate_q;
    tvalid_d   = 1'b0;
    deny_d     = 1'b0;
    exit_err_d = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    reserved   = (state_q != IDLE);

    // Exits are honoured in every state, except on a free or reserved slot.
    if (bus.exit_req) begin
      if (cap_q[bus.exit_slot] && !(reserved && bus.exit_slot == resv_q)) begin
        cap_d[bus.exit_slot] = 1'b0;
      end else begin
        exit_err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        gate_d = 1'b0;
        // Full check uses the pre-exit bitmap; an already-set slot is a fault.
        if (bus.entry) begin
          if (full_q || cap_q[bus.park_number]) begin
            deny_d = 1'b1;
          end else begin
            resv_d                 = bus.park_number;
            cap_d[bus.park_number] = 1'b1;
            tvalid_d               = 1'b1;
            tslot_d                = bus.park_number;
            state_d                = GRANT;
          end
        end
      end
      GRANT: begin
        gate_d  = 1'b1;
        cnt_d   = 8'd0;
        state_d = WAIT_CAR;
      end
      WAIT_CAR: begin
        if (bus.car_passed) begin
          gate_d  = 1'b0;
          commit  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          cap_d[resv_q] = 1'b0;
          gate_d        = 1'b0;
          abort         = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          gate_d = 1'b1;
        end
      end
      default: begin
        gate_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    full_d = &cap_d;
  end

  park_popcount u_popcount (
    .map_i   (cap_d),
    .zeros_o (free_d)
  );

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      cap_q      <= '0;
      resv_q     <= '0;
      tslot_q    <= '0;
      gate_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      deny_q     <= 1'b0;
      exit_err_q <= 1'b0;
      full_q     <= 1'b0;
      free_q     <= 4'd8;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      resv_q     <= resv_d;
      tslot_q    <= tslot_d;
      gate_q     <= gate_d;
      tvalid_q   <= tvalid_d;
      deny_q     <= deny_d;
      exit_err_q <= exit_err_d;
      full_q     <= full_d;
      free_q     <= free_d;
    end
  end

  assign bus.parking_capacity = cap_q;
  assign bus.gate_open        = gate_q;
  assign bus.ticket_valid     = tvalid_q;
  assign bus.ticket_slot      = tslot_q;
  assign bus.full             = full_q;
  assign bus.free_count       = free_q;
  assign bus.deny             = deny_q;
  assign bus.exit_err         = exit_err_q;

`ifdef PARK_STATS_EN
  logic [15:0] entries_q;
  logic [7:0]  timeouts_q;

  // Saturating counters of committed and aborted entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q  <= 16'd0;
      timeouts_q <= 8'd0;
    end else begin
      if (commit && entries_q != 16'hFFFF) entries_q  <= entries_q + 16'd1;
      if (abort && timeouts_q != 8'hFF)    timeouts_q <= timeouts_q + 8'd1;
    end
  end

  assign bus.total_entries  = entries_q;
  assign bus.total_timeouts = timeouts_q;
`endif

endmodule : park_slot_manager

// File: tb/tb_park_slot_manager.sv
// Directed self-checking bench for park_slot_manager. Build with
// PARK_STATS_EN defined to also check the statistics counters.
module tb_park_slot_manager;
  import park_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  int   open_cycles;

  always #5 clk = ~clk;

  park_slot_manager_if bus ();

  park_slot_manager #(.GATE_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full successful park of one car into the given slot.
  task automatic park(input logic [2:0] slot);
    bus.entry       = 1'b1;
    bus.park_number = slot;
    step();
    bus.entry = 1'b0;
    step();
    bus.car_passed = 1'b1;
    step();
    bus.car_passed = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.entry       = 1'b0;
    bus.park_number = 3'd0;
    bus.car_passed  = 1'b0;
    bus.exit_req    = 1'b0;
    bus.exit_slot   = 3'd0;
    step();
    step();
    rst = 1'b0;

    // 1: reset then idle
    check("rst_free", bus.free_count, 16'd8);
    repeat (3) step();
    check("idle_cap", bus.parking_capacity, 16'h00);
    check("idle_free", bus.free_count, 16'd8);
    check("idle_full", bus.full, 16'd0);
    check("idle_gate", bus.gate_open, 16'd0);

    // 2: entry into slot 3, car passes 4 cycles after gate opens
    bus.entry       = 1'b1;
    bus.park_number = 3'd3;
    step();
    bus.entry = 1'b0;
    check("t2_tvalid", bus.ticket_valid, 16'd1);
    check("t2_tslot", bus.ticket_slot, 16'd3);
    check("t2_cap", bus.parking_capacity, 16'h08);
    check("t2_gate_early", bus.gate_open, 16'd0);
    step();
    check("t2_gate", bus.gate_open, 16'd1);
    check("t2_tvalid_drop", bus.ticket_valid, 16'd0);
    repeat (3) step();
    check("t2_gate_wait", bus.gate_open, 16'd1);
    bus.car_passed = 1'b1;
    step();
    bus.car_passed = 1'b0;
    check("t2_gate_closed", bus.gate_open, 16'd0);
    check("t2_cap_commit", bus.parking_capacity, 16'h08);
    check("t2_free", bus.free_count, 16'd7);
`ifdef PARK_STATS_EN
    check("t2_entries", bus.total_entries, 16'd1);
`endif

    // entry on an already-set slot is refused
    bus.entry       = 1'b1;
    bus.park_number = 3'd3;
    step();
    check("fault_deny", bus.deny, 16'd1);
    check("fault_cap", bus.parking_capacity, 16'h08);

    // 3: reserve slot 5, never pass: gate open 16 cycles, then abort
    bus.park_number = 3'd5;
    step();
    bus.entry = 1'b0;
    check("t3_tslot", bus.ticket_slot, 16'd5);
    check("t3_cap_resv", bus.parking_capacity, 16'h28);
    step();
    open_cycles = bus.gate_open ? 1 : 0;
    for (int i = 0; i < 40 && bus.gate_open; i++) begin
      step();
      if (bus.gate_open) open_cycles++;
    end
    check("t3_open_cycles", 16'(open_cycles), 16'd16);
    check("t3_cap_abort", bus.parking_capacity, 16'h08);
    check("t3_free", bus.free_count, 16'd7);
`ifdef PARK_STATS_EN
    check("t3_timeouts", bus.total_timeouts, 16'd1);
`endif

    // 4: fill the lot, then a further entry is denied
    park(3'd0); park(3'd1); park(3'd2); park(3'd4);
    park(3'd5); park(3'd6); park(3'd7);
    check("t4_cap_full", bus.parking_capacity, 16'hFF);
    check("t4_full", bus.full, 16'd1);
    check("t4_free", bus.free_count, 16'd0);
    bus.entry       = 1'b1;
    bus.park_number = 3'd0;
    step();
    bus.entry = 1'b0;
    check("t4_deny", bus.deny, 16'd1);
    check("t4_no_ticket", bus.ticket_valid, 16'd0);
    step();
    check("t4_deny_drop", bus.deny, 16'd0);
    check("t4_no_gate", bus.gate_open, 16'd0);
`ifdef PARK_STATS_EN
    check("t4_entries", bus.total_entries, 16'd8);
`endif

    // 5: exit of slot 2 same cycle as entry on full lot
    bus.entry       = 1'b1;
    bus.park_number = 3'd2;
    bus.exit_req    = 1'b1;
    bus.exit_slot   = 3'd2;
    step();
    bus.exit_req = 1'b0;
    check("t5_deny", bus.deny, 16'd1);
    check("t5_cap", bus.parking_capacity, 16'hFB);
    check("t5_free", bus.free_count, 16'd1);
    check("t5_full", bus.full, 16'd0);
    step();
    bus.entry = 1'b0;
    check("t5_tvalid", bus.ticket_valid, 16'd1);
    check("t5_tslot", bus.ticket_slot, 16'd2);
    check("t5_cap_refill", bus.parking_capacity, 16'hFF);
    step();
    bus.car_passed = 1'b1;
    step();
    bus.car_passed = 1'b0;

    // 6: legal exit, exit on free slot, exit on reserved slot, then reset
    bus.exit_req  = 1'b1;
    bus.exit_slot = 3'd6;
    step();
    check("t6_exit_ok", bus.parking_capacity, 16'hBF);
    check("t6_exit_ok_err", bus.exit_err, 16'd0);
    step();
    bus.exit_req = 1'b0;
    check("t6_free_err", bus.exit_err, 16'd1);
    check("t6_free_cap", bus.parking_capacity, 16'hBF);
    bus.entry       = 1'b1;
    bus.park_number = 3'd6;
    step();
    bus.entry = 1'b0;
    check("t6_resv_cap", bus.parking_capacity, 16'hFF);
    check("t6_err_drop", bus.exit_err, 16'd0);
    step();
    bus.exit_req  = 1'b1;
    bus.exit_slot = 3'd6;
    step();
    bus.exit_req = 1'b0;
    check("t6_resv_err", bus.exit_err, 16'd1);
    check("t6_resv_keep", bus.parking_capacity, 16'hFF);
    check("t6_gate_still", bus.gate_open, 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_cap", bus.parking_capacity, 16'h00);
    check("t6_rst_gate", bus.gate_open, 16'd0);
    check("t6_rst_free", bus.free_count, 16'd8);
    check("t6_rst_full", bus.full, 16'd0);
    check("t6_rst_tslot", bus.ticket_slot, 16'd0);
    check("t6_rst_err", bus.exit_err, 16'd0);
`ifdef PARK_STATS_EN
    check("t6_rst_entries", bus.total_entries, 16'd0);
    check("t6_rst_timeouts", bus.total_timeouts, 16'd0);
`endif
    step();
    check("t6_post_gate", bus.gate_open, 16'd0);
    check("t6_post_tvalid", bus.ticket_valid, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_park_slot_manager
